// File: rtl/clock_timekeeper.sv
// clock_timekeeper: time-of-day counter with Set/Up/Down time setting, hold-to-repeat,
// set-mode timeout and 12/24-hour BCD display outputs.
module clock_timekeeper #(
  parameter bit HOUR_MODE_24 = 1'b1,
  parameter int REPEAT_DELAY = 4,
  parameter int SET_TIMEOUT  = 30
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tick_1Hz,
  input  logic       i_Tick_Repeat,
  input  logic       i_Set,
  input  logic       i_Up_Held,
  input  logic       i_Down_Held,
  output logic [3:0] o_Units_Sec,
  output logic [2:0] o_Tens_Sec,
  output logic [3:0] o_Units_Min,
  output logic [2:0] o_Tens_Min,
  output logic [3:0] o_Units_Hour,
  output logic [1:0] o_Tens_Hour,
  output logic       o_PM,
  output logic       o_Setting,
  output logic [1:0] o_Blink_Field
);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int TW = $clog2(SET_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;
  state_t          state_q, state_d;
  logic [4:0]      hour_q, hour_d, hm, hdisp;
  logic [3:0]      sec_u_q, sec_u_d, min_u_q, min_u_d, hour_u_q, hour_u_d;
  logic [2:0]      sec_t_q, sec_t_d, min_t_q, min_t_d;
  logic [1:0]      hour_t_q, hour_t_d, blink_q, blink_d;
  logic            pm_q, pm_d, up_q, dn_q;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   to_q, to_d;
  logic            one_up, one_dn, sustained, press, rep, step, run_tick, sec_wrap, min_wrap;
  assign one_up    = i_Up_Held & ~i_Down_Held;
  assign one_dn    = i_Down_Held & ~i_Up_Held;
  assign sustained = (one_up & up_q) | (one_dn & dn_q);
  assign press     = (one_up & ~up_q) | (one_dn & ~dn_q);
  assign rep       = sustained & i_Tick_Repeat & (hold_q == HW'(REPEAT_DELAY));
  assign step      = (press | rep) & (state_q != RUN) & ~i_Set;
  assign run_tick  = i_Tick_1Hz & (state_q == RUN);
  assign sec_wrap  = (sec_u_q == 4'd9) & (sec_t_q == 3'd5);
  assign min_wrap  = (min_u_q == 4'd9) & (min_t_q == 3'd5);
  always_comb begin
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    hour_d  = hour_q;
    if (run_tick) begin
      sec_u_d = sec_u_q == 4'd9 ? 4'd0 : sec_u_q + 4'd1;
      sec_t_d = sec_u_q != 4'd9 ? sec_t_q : sec_t_q == 3'd5 ? 3'd0 : sec_t_q + 3'd1;
      if (sec_wrap) begin
        min_u_d = min_u_q == 4'd9 ? 4'd0 : min_u_q + 4'd1;
        min_t_d = min_u_q != 4'd9 ? min_t_q : min_t_q == 3'd5 ? 3'd0 : min_t_q + 3'd1;
        if (min_wrap) hour_d = hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1;
      end
    end
    if (step && state_q == SET_HOUR)
      hour_d = one_up ? (hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1)
                      : (hour_q == 5'd0 ? 5'd23 : hour_q - 5'd1);
    if (step && state_q == SET_MIN) begin
      min_u_d = one_up ? (min_u_q == 4'd9 ? 4'd0 : min_u_q + 4'd1)
                       : (min_u_q == 4'd0 ? 4'd9 : min_u_q - 4'd1);
      min_t_d = one_up ? (min_u_q != 4'd9 ? min_t_q : min_t_q == 3'd5 ? 3'd0 : min_t_q + 3'd1)
                       : (min_u_q != 4'd0 ? min_t_q : min_t_q == 3'd0 ? 3'd5 : min_t_q - 3'd1);
    end
    if (i_Set && state_q == SET_MIN) begin
      sec_u_d = 4'd0;
      sec_t_d = 3'd0;
    end
  end
  // Set beats a coincident step or timeout; a step beats a coincident 1 Hz tick.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    hold_d  = !sustained ? '0 : (i_Tick_Repeat && hold_q != HW'(REPEAT_DELAY)) ? hold_q + 1'b1 : hold_q;
    if (i_Set) begin
      state_d = state_q == RUN ? SET_HOUR : state_q == SET_HOUR ? SET_MIN : RUN;
      to_d    = '0;
    end else if (state_q == RUN || step) begin
      to_d = '0;
    end else if (i_Tick_1Hz) begin
      state_d = to_q == TW'(SET_TIMEOUT - 1) ? RUN : state_q;
      to_d    = to_q == TW'(SET_TIMEOUT - 1) ? '0 : to_q + 1'b1;
    end
    blink_d = {state_d == SET_HOUR, state_d == SET_MIN};
  end
  always_comb begin
    hm       = hour_d >= 5'd12 ? hour_d - 5'd12 : hour_d;
    hdisp    = HOUR_MODE_24 ? hour_d : (hm == 5'd0 ? 5'd12 : hm);
    hour_t_d = hdisp >= 5'd20 ? 2'd2 : hdisp >= 5'd10 ? 2'd1 : 2'd0;
    hour_u_d = 4'(hdisp - 5'd10 * 5'(hour_t_d));
    pm_d     = !HOUR_MODE_24 && hour_d >= 5'd12;
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= RUN;
      hour_q   <= '0;
      sec_u_q  <= '0;
      sec_t_q  <= '0;
      min_u_q  <= '0;
      min_t_q  <= '0;
      hour_u_q <= HOUR_MODE_24 ? 4'd0 : 4'd2;
      hour_t_q <= HOUR_MODE_24 ? 2'd0 : 2'd1;
      pm_q     <= 1'b0;
      blink_q  <= 2'b00;
      hold_q   <= '0;
      to_q     <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      sec_u_q  <= sec_u_d;
      sec_t_q  <= sec_t_d;
      min_u_q  <= min_u_d;
      min_t_q  <= min_t_d;
      hour_u_q <= hour_u_d;
      hour_t_q <= hour_t_d;
      pm_q     <= pm_d;
      blink_q  <= blink_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      up_q     <= i_Up_Held;
      dn_q     <= i_Down_Held;
    end
  end
  assign o_Units_Sec   = sec_u_q;
  assign o_Tens_Sec    = sec_t_q;
  assign o_Units_Min   = min_u_q;
  assign o_Tens_Min    = min_t_q;
  assign o_Units_Hour  = hour_u_q;
  assign o_Tens_Hour   = hour_t_q;
  assign o_PM          = pm_q;
  assign o_Setting     = |blink_q;
  assign o_Blink_Field = blink_q;
endmodule

// File: tb/tb_clock_timekeeper.sv
// tb_clock_timekeeper: scoreboard bench driving a 24 h and a 12 h instance with shared stimulus.
module tb_clock_timekeeper;
  localparam int RD = 4;
  localparam int ST = 30;
  logic clk = 1'b0, rst_n = 1'b0, t1 = 1'b0, tr = 1'b0, set = 1'b0, up = 1'b0, dn = 1'b0;
  logic [3:0] a_us, a_um, a_uh, b_us, b_um, b_uh;
  logic [2:0] a_ts, a_tm, b_ts, b_tm;
  logic [1:0] a_th, a_bf, b_th, b_bf;
  logic a_pm, a_st, b_pm, b_st;
  logic [23:0] v24, v12;
  bit b_up = 0, b_dn = 0, b_rst = 0;
  int vectors = 0, miscompares = 0;
  int m_hour, m_min, m_sec, m_mode, m_hold, m_to;
  bit m_upp, m_dnp;
  typedef struct {logic [23:0] e24; logic [23:0] e12;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  clock_timekeeper #(.HOUR_MODE_24(1'b1), .REPEAT_DELAY(RD), .SET_TIMEOUT(ST)) dut24 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tick_1Hz(t1), .i_Tick_Repeat(tr), .i_Set(set),
    .i_Up_Held(up), .i_Down_Held(dn), .o_Units_Sec(a_us), .o_Tens_Sec(a_ts),
    .o_Units_Min(a_um), .o_Tens_Min(a_tm), .o_Units_Hour(a_uh), .o_Tens_Hour(a_th),
    .o_PM(a_pm), .o_Setting(a_st), .o_Blink_Field(a_bf));
  clock_timekeeper #(.HOUR_MODE_24(1'b0), .REPEAT_DELAY(RD), .SET_TIMEOUT(ST)) dut12 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tick_1Hz(t1), .i_Tick_Repeat(tr), .i_Set(set),
    .i_Up_Held(up), .i_Down_Held(dn), .o_Units_Sec(b_us), .o_Tens_Sec(b_ts),
    .o_Units_Min(b_um), .o_Tens_Min(b_tm), .o_Units_Hour(b_uh), .o_Tens_Hour(b_th),
    .o_PM(b_pm), .o_Setting(b_st), .o_Blink_Field(b_bf));
  assign v24 = {a_us, a_ts, a_um, a_tm, a_uh, a_th, a_pm, a_st, a_bf};
  assign v12 = {b_us, b_ts, b_um, b_tm, b_uh, b_th, b_pm, b_st, b_bf};
  function automatic logic [23:0] pack(bit mode24);
    int h = mode24 ? m_hour : (m_hour % 12 == 0 ? 12 : m_hour % 12);
    return {4'(m_sec % 10), 3'(m_sec / 10), 4'(m_min % 10), 3'(m_min / 10), 4'(h % 10), 2'(h / 10),
            !mode24 && m_hour >= 12, m_mode != 0, m_mode == 1, m_mode == 2};
  endfunction
  function automatic void chk(string name, logic [23:0] got, logic [23:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endfunction
  task automatic model_reset();
    m_hour = 0; m_min = 0; m_sec = 0; m_mode = 0; m_hold = 0; m_to = 0; m_upp = 0; m_dnp = 0;
  endtask
  task automatic advance();
    int t = (m_hour * 3600 + m_min * 60 + m_sec + 1) % 86400;
    m_hour = t / 3600; m_min = (t / 60) % 60; m_sec = t % 60;
  endtask
  task automatic model_step();
    bit ou, od, sus, prs, stp;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ou = up && !dn;
    od = dn && !up;
    sus = (ou && m_upp) || (od && m_dnp);
    prs = (ou && !m_upp) || (od && !m_dnp);
    stp = (prs || (sus && tr && m_hold >= RD)) && m_mode != 0 && !set;
    m_hold = !sus ? 0 : (tr && m_hold < RD) ? m_hold + 1 : m_hold;
    d = ou ? 1 : -1;
    if (set) begin
      if (m_mode == 0 && t1) advance();
      if (m_mode == 2) m_sec = 0;
      m_mode = (m_mode + 1) % 3;
      m_to = 0;
    end else if (m_mode == 0) begin
      if (t1) advance();
    end else if (stp) begin
      if (m_mode == 1) m_hour = (m_hour + d + 24) % 24;
      else m_min = (m_min + d + 60) % 60;
      m_to = 0;
    end else if (t1) begin
      m_to++;
      if (m_to == ST) begin
        m_mode = 0;
        m_to = 0;
      end
    end
    m_upp = up;
    m_dnp = dn;
  endtask
  task automatic cyc(bit a_t1 = 0, bit a_tr = 0, bit a_set = 0);
    exp_t e;
    @(negedge clk);
    t1 = a_t1; tr = a_tr; set = a_set; up = b_up; dn = b_dn; rst_n = b_rst;
    model_step();
    e.e24 = pack(1);
    e.e12 = pack(0);
    q.push_back(e);
  endtask
  task automatic tap_up();
    b_up = 1; cyc(); b_up = 0; cyc();
  endtask
  task automatic tap_dn();
    b_dn = 1; cyc(); b_dn = 0; cyc();
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out24", v24, e.e24);
        chk("out12", v12, e.e12);
      end
    end
  end
  initial begin
    model_reset();
    repeat (3) cyc();
    b_rst = 1;
    repeat (3661) cyc(1);
    b_rst = 0; cyc(); b_rst = 1; cyc();
    cyc(0, 0, 1); tap_dn();
    cyc(0, 0, 1); tap_dn();
    cyc(0, 0, 1);
    repeat (60) cyc(1);
    cyc(0, 0, 1);
    repeat (13) tap_up();
    cyc(0, 0, 1); tap_dn(); tap_up();
    cyc(0, 0, 1);
    cyc(0, 0, 1); cyc(0, 0, 1);
    repeat (10) tap_up();
    b_up = 1; cyc();
    repeat (10) begin cyc(0, 1); cyc(); end
    b_up = 0; cyc();
    b_up = 1; b_dn = 1;
    repeat (10) begin cyc(0, 1); cyc(); end
    b_up = 0; b_dn = 0; cyc();
    cyc(0, 0, 1);
    repeat (7) cyc(1);
    cyc(0, 0, 1);
    repeat (30) cyc(1);
    cyc(0, 0, 1);
    repeat (29) cyc(1);
    tap_up();
    repeat (29) cyc(1);
    cyc(1);
    repeat (5) cyc(1);
    cyc(0, 0, 1); cyc(0, 0, 1); tap_up(); tap_up();
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst24", v24, pack(1));
    chk("async_rst12", v12, pack(0));
    b_rst = 0; cyc(); cyc();
    b_rst = 1; cyc();
    repeat (3000) begin
      if ($urandom_range(11) == 0) b_up = ~b_up;
      if ($urandom_range(11) == 0) b_dn = ~b_dn;
      b_rst = $urandom_range(599) != 0;
      cyc($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(24) == 0);
    end
    b_up = 0; b_dn = 0; b_rst = 1;
    cyc(); cyc();
    @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
